// File: rtl/core_pkg.sv
// Shared core definitions for the decode-stage hazard/flush control.
// Holds the NOP pc_sel, load-bit position and the shadow-entry layout.
package core_pkg;

  localparam int REGW = 5;
  localparam int LDST_LOAD_BIT = 4;
  localparam logic [2:0] PC_SEL_NOP = 3'd7;

  typedef struct packed {
    logic            v;
    logic [REGW-1:0] rd;
  } shadow_t;

  localparam int SHADOW_W = $bits(shadow_t);

endpackage

// File: rtl/load_shadow_pipe.sv
// Shift register of loads in flight past ID, {v, rd} per entry.
// Entry 0 is the instruction now in EX; one match bit per entry and source.
module load_shadow_pipe #(
  parameter int REGW  = 5,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_v,
  input  logic [REGW-1:0]  push_rd,
  input  logic [REGW-1:0]  rs1,
  input  logic [REGW-1:0]  rs2,
  output logic [DEPTH-1:0] hit1,
  output logic [DEPTH-1:0] hit2
);

  logic [DEPTH-1:0] v;
  logic [REGW-1:0]  rd_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++)
        rd_q[i] <= '0;
    end else begin
      v[0]    <= push_v;
      rd_q[0] <= push_rd;
      for (int i = 1; i < DEPTH; i++) begin
        v[i]    <= v[i-1];
        rd_q[i] <= rd_q[i-1];
      end
    end
  end

  // x0 never carries a real result, so it never matches
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = v[i] & (rd_q[i] != '0)
              & (rs1 == rd_q[i]);
      hit2[i] = v[i] & (rd_q[i] != '0)
              & (rs2 == rd_q[i]);
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage load-use stall, redirect flush and gating of the control bundle.
// Also keeps saturating stall and killed-slot counters.
module id_hazard_ctrl
  import core_pkg::*;
#(
  parameter int         REGW        = core_pkg::REGW,
  parameter int         FLUSH_DEPTH = 2,
  parameter int         LOAD_LAT    = 1,
  parameter int         CNTW        = 32,
  parameter logic [2:0] PC_SEL_NOP  = core_pkg::PC_SEL_NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic [REGW-1:0] rd,
  input  logic            we_rf_d,
  input  logic [4:0]      ld_st_d,
  input  logic [2:0]      pc_sel_d,
  input  logic            redirect,
  output logic            we_rf,
  output logic [4:0]      ld_st,
  output logic [2:0]      pc_sel,
  output logic            stall,
  output logic            kill,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  localparam int FW = $clog2(FLUSH_DEPTH + 1);

  logic [FW-1:0]       fcnt;
  logic                flushing;
  logic                haz;
  logic                gate;
  logic                push_v;
  logic [LOAD_LAT-1:0] hit1;
  logic [LOAD_LAT-1:0] hit2;

  assign flushing = redirect | (fcnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n)
      fcnt <= '0;
    else if (redirect)
      fcnt <= FW'(FLUSH_DEPTH - 1);
    else if (fcnt != '0)
      fcnt <= fcnt - FW'(1);
  end

  load_shadow_pipe #(
    .REGW  (REGW),
    .DEPTH (LOAD_LAT)
  ) u_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_v  (push_v),
    .push_rd (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .hit1    (hit1),
    .hit2    (hit2)
  );

  assign haz = id_valid
             & ((rs1_used & (|hit1))
              | (rs2_used & (|hit2)));

  // flush wins over stall; reset looks like a kill
  assign kill  = ~rst_n | flushing;
  assign stall = rst_n & haz & ~flushing;
  assign gate  = kill | stall | ~id_valid;

  assign push_v = id_valid & ~kill & ~stall
                & ld_st_d[LDST_LOAD_BIT] & we_rf_d;

  always_comb begin
    we_rf  = we_rf_d;
    ld_st  = ld_st_d;
    pc_sel = pc_sel_d;
    if (gate) begin
      we_rf  = 1'b0;
      ld_st  = '0;
      pc_sel = PC_SEL_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNTW'(1);
      if (flushing && id_valid && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

endmodule
